// File: rtl/sumador_arbiter_if.sv
// Request, adder-launch and response signals shared by sumador_arbiter and its surroundings.
// The op_count/carry_count members exist only when SUMADOR_ARB_STATS_EN is defined.
interface sumador_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;

  logic                  add_en;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_cout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  busy;

`ifdef SUMADOR_ARB_STATS_EN
  logic [15:0]           op_count;
  logic [15:0]           carry_count;

  // slave is the arbiter; master is the requesters, result consumer and adder together
  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_en, add_a, add_b, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy,
    output op_count, carry_count
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_en, add_a, add_b, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy,
    input  op_count, carry_count
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_en, add_a, add_b, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_en, add_a, add_b, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );
`endif

endinterface

// File: rtl/sumador_arbiter.sv
// Round-robin arbiter sharing one external adder among NREQ requesters.
// Define SUMADOR_ARB_STATS_EN to add the op_count/carry_count handshake counters.
//
// state | meaning
// IDLE  | scan requesters from rr_ptr, accept the first valid one
// ISSUE | registered operands on add_a/add_b/add_cin, add_en pulsed
// WAIT  | counting adder latency, capture result when cnt reaches ADD_LAT
// RESP  | result held on rsp_* until rsp_ready
module sumador_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  sumador_arbiter_if.slave bus
);
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ADD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_nxt;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  id_q;
  logic             found;
  logic             accept;
  logic             capture;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Rotating-priority scan: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int s;
    found  = 1'b0;
    winner = '0;
    s      = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      if (!found && bus.req_valid[ID_W'(s)]) begin
        found  = 1'b1;
        winner = ID_W'(s);
      end
    end
  end

  always_comb begin
    int s;
    s = int'(winner) + 1;
    if (s >= NREQ) s = 0;
    rr_nxt = ID_W'(s);
  end

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == ID_W'(i)) begin
        a_sel   = bus.req_a[i*WIDTH +: WIDTH];
        b_sel   = bus.req_b[i*WIDTH +: WIDTH];
        cin_sel = bus.req_cin[i];
      end
    end
  end

  assign accept  = (state == IDLE) && found;
  assign capture = ((state == ISSUE) && (ADD_LAT == 0)) ||
                   ((state == WAIT) && (cnt == LAT_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = (ADD_LAT == 0) ? RESP : WAIT;
      WAIT:    if (cnt == LAT_CNT) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is also gated by rst_n so the grant disappears the moment reset asserts
  always_comb begin
    bus.req_ready = '0;
    if ((state == IDLE) && found && rst_n) bus.req_ready[winner] = 1'b1;
    bus.add_en    = (state == ISSUE);
    bus.rsp_valid = (state == RESP);
    bus.busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
    end else if (accept) begin
      rr_ptr <= rr_nxt;
      id_q   <= winner;
      a_q    <= a_sel;
      b_q    <= b_sel;
      cin_q  <= cin_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= CNT_W'(1);
    end else if ((state == WAIT) && (cnt != LAT_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (capture) begin
      sum_q  <= bus.add_sum;
      cout_q <= bus.add_cout;
    end
  end

  assign bus.add_a    = a_q;
  assign bus.add_b    = b_q;
  assign bus.add_cin  = cin_q;
  assign bus.rsp_id   = id_q;
  assign bus.rsp_sum  = sum_q;
  assign bus.rsp_cout = cout_q;

`ifdef SUMADOR_ARB_STATS_EN
  logic        rsp_fire;
  logic [15:0] op_q;
  logic [15:0] carry_q;

  assign rsp_fire = (state == RESP) && bus.rsp_ready;

  // op count wraps, carry count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      carry_q <= '0;
    end else if (rsp_fire) begin
      op_q <= op_q + 16'd1;
      if (cout_q && (carry_q != 16'hFFFF)) carry_q <= carry_q + 16'd1;
    end
  end

  assign bus.op_count    = op_q;
  assign bus.carry_count = carry_q;
`endif

endmodule

// File: tb/tb_sumador_arbiter.sv
// Scoreboard bench for sumador_arbiter: expected results are queued at each accept
// and compared when the response handshake completes.
`timescale 1ns/1ps
module tb_sumador_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int LAT      = 1;
  localparam int LAT_PIPE = (LAT > 0) ? LAT : 1;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   n_checks   = 0;
  int   n_errors   = 0;
  int   cyc        = 0;
  int   model_ptr  = 0;
  int   acc_cyc    = 0;
  int   tb_ops     = 0;
  int   tb_carry   = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  int   grant_log[$];

  sumador_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  sumador_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ADD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: result only follows a launch, delayed by LAT registers
  logic [8:0] add_pipe [0:LAT_PIPE-1];
  wire  [8:0] add_now = bus.add_en ?
                        ({1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'b0, bus.add_cin}) : 9'h0;
  always @(posedge clk) begin
    add_pipe[0] <= add_now;
    for (int i = 1; i < LAT_PIPE; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign {bus.add_cout, bus.add_sum} = (LAT == 0) ? add_now : add_pipe[LAT_PIPE-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    int         w;
    int         s;
    exp_t       e;
    logic [8:0] full;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        sb.delete();
        model_ptr  = 0;
        prev_valid = 1'b0;
        tb_ops     = 0;
        tb_carry   = 0;
      end else begin
        if (!bus.busy && (bus.req_valid != '0)) begin
          w = -1;
          for (int k = 0; k < NREQ; k++) begin
            s = (model_ptr + k) % NREQ;
            if ((w < 0) && bus.req_valid[s]) w = s;
          end
          chk("grant", bus.req_ready, 32'(1 << w));
          full   = {1'b0, bus.req_a[w*WIDTH +: WIDTH]} + {1'b0, bus.req_b[w*WIDTH +: WIDTH]}
                   + {8'b0, bus.req_cin[w]};
          e.id   = 2'(w);
          e.sum  = full[7:0];
          e.cout = full[8];
          sb.push_back(e);
          grant_log.push_back(w);
          model_ptr = (w + 1) % NREQ;
          acc_cyc   = cyc;
        end else if (bus.busy && (bus.req_valid != '0)) begin
          chk("ready_busy", bus.req_ready, 0);
        end
        if (bus.rsp_valid && !prev_valid) chk("latency", cyc - acc_cyc, 2 + LAT);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_sum", bus.rsp_sum, e.sum);
            chk("rsp_cout", bus.rsp_cout, e.cout);
            tb_ops++;
            if (e.cout) tb_carry++;
          end
        end
        prev_valid = bus.rsp_valid;
      end
    end
  endtask

  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b, input logic cin);
    bit got = 1'b0;
    bus.req_a[idx*WIDTH +: WIDTH] = a;
    bus.req_b[idx*WIDTH +: WIDTH] = b;
    bus.req_cin[idx]   = cin;
    bus.req_valid[idx] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready[idx];
    end
    chk("accept_wait", got, 1);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid;
    end
    chk("rsp_wait", got, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.busy && (sb.size() == 0);
    end
    chk("idle_wait", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bit got;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset values, with requests pending to show the grant is masked
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_add_en", bus.add_en, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_sum", bus.rsp_sum, 0);
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op
    do_op(0, 8'h3C, 8'h05, 1'b0);
    wait_rsp();
    chk("single_sum", bus.rsp_sum, 8'h41);
    chk("single_cout", bus.rsp_cout, 0);
    chk("single_id", bus.rsp_id, 0);
    wait_idle();

    // Carry out
    do_op(2, 8'hFF, 8'h01, 1'b1);
    wait_rsp();
    chk("carry_sum", bus.rsp_sum, 8'h01);
    chk("carry_cout", bus.rsp_cout, 1);
    chk("carry_id", bus.rsp_id, 2);
    wait_idle();

    // Backpressure with another requester waiting
    bus.rsp_ready = 1'b0;
    do_op(1, 8'h12, 8'h34, 1'b1);
    bus.req_a[3*WIDTH +: WIDTH] = 8'hA0;
    bus.req_b[3*WIDTH +: WIDTH] = 8'h0B;
    bus.req_cin[3]   = 1'b0;
    bus.req_valid[3] = 1'b1;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_sum", bus.rsp_sum, 8'h47);
      chk("bp_id", bus.rsp_id, 1);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_busy", bus.busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_next_grant", bus.req_ready, 4'b1000);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    wait_idle();

    // Asynchronous reset while an op is in flight
    do_op(0, 8'h5A, 8'hC3, 1'b1);
    @(negedge clk);
    chk("inflight_add_en", bus.add_en, 1);
    if (LAT > 0) @(negedge clk);
    chk("inflight_busy", bus.busy, 1);
    bus.req_a[1*WIDTH +: WIDTH] = 8'h10;
    bus.req_b[1*WIDTH +: WIDTH] = 8'h20;
    bus.req_cin[1]   = 1'b0;
    bus.req_valid[1] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_add_en", bus.add_en, 0);
    chk("arst_add_a", bus.add_a, 0);
    chk("arst_add_b", bus.add_b, 0);
    chk("arst_add_cin", bus.add_cin, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_sum", bus.rsp_sum, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_ready != '0);
    end
    chk("arst_first_grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    wait_idle();

    // Fairness: pointer back to 0, all requesters held for 8 accepts
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = 8'(i * 40 + 7);
      bus.req_b[i*WIDTH +: WIDTH] = 8'(200 + i * 17);
      bus.req_cin[i] = i[0];
    end
    start = grant_log.size();
    bus.req_valid = '1;
    for (int i = 0; i < 200 && (grant_log.size() < start + 8); i++) @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();
    chk("fair_count", grant_log.size() - start, 8);
    for (int k = 0; k < 8; k++) begin
      if (start + k < grant_log.size()) chk("fair_order", grant_log[start+k], k % NREQ);
    end

`ifdef SUMADOR_ARB_STATS_EN
    chk("op_count", bus.op_count, 16'(tb_ops));
    chk("carry_count", bus.carry_count, 16'(tb_carry));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
